// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter (CPU port vs DMA/loader port).
package dmem_arb_pkg;

  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = ARB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef struct packed {
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]       we;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } req_t;

  // Counter must be able to hold the value limit itself.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Fixed CPU priority with a DMA starvation override; grants are combinational, no backpressure.
// Optional DMEM_ARB_LOCK_EN adds cpu_lock_i, which holds DMA off after a CPU grant.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req_i,
  input  logic dma_req_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic cpu_lock_i,
`endif
  output logic cpu_gnt_o,
  output logic dma_gnt_o
);

  localparam int CW = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          lock_hold;
  logic          force_dma;

`ifdef DMEM_ARB_LOCK_EN
  logic last_cpu_q, last_cpu_d;

  assign lock_hold = cpu_lock_i & last_cpu_q;

  always_comb begin
    last_cpu_d = last_cpu_q;
    if (cpu_gnt_o)      last_cpu_d = 1'b1;
    else if (dma_gnt_o) last_cpu_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_cpu_q <= 1'b0;
    else     last_cpu_q <= last_cpu_d;
  end
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    force_dma = (starve_q == LIMIT) && !lock_hold;
    dma_gnt_o = dma_req_i && !lock_hold && (!cpu_req_i || force_dma);
    cpu_gnt_o = cpu_req_i && !dma_gnt_o;

    // Saturates at LIMIT, so a lock held long enough leaves DMA armed to win on release.
    starve_d = starve_q;
    if (!dma_req_i || dma_gnt_o) starve_d = '0;
    else if (starve_q != LIMIT)  starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between CPU and DMA: same-cycle grant, read data 1 cycle later,
// losers simply wait with req held. Define DMEM_ARB_LOCK_EN to add the cpu_lock_i atomic hold.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
  input  logic [DATA_WIDTH/8-1:0]   cpu_we_i,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata_i,
  output logic                      cpu_gnt_o,
  output logic                      cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0]     cpu_rdata_o,
  input  logic                      dma_req_i,
  input  logic [ADDR_WIDTH-1:0]     dma_addr_i,
  input  logic [DATA_WIDTH/8-1:0]   dma_we_i,
  input  logic [DATA_WIDTH-1:0]     dma_wdata_i,
  output logic                      dma_gnt_o,
  output logic                      dma_rvalid_o,
  output logic [DATA_WIDTH-1:0]     dma_rdata_o,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                      cpu_lock_i,
`endif
  output logic                      mem_en_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]   mem_we_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  logic   cpu_req_act, dma_req_act;
  logic   cpu_gnt, dma_gnt;
  req_t   cpu_req_s, dma_req_s, gnt_req;
  owner_e owner_q, owner_d;
  logic   unused_addr_bits;

  // Requests are masked in reset so every output reads 0 while rst is high.
  assign cpu_req_act = cpu_req_i & ~rst;
  assign dma_req_act = dma_req_i & ~rst;

  dmem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpu_req_act),
    .dma_req_i  (dma_req_act),
`ifdef DMEM_ARB_LOCK_EN
    .cpu_lock_i (cpu_lock_i),
`endif
    .cpu_gnt_o  (cpu_gnt),
    .dma_gnt_o  (dma_gnt)
  );

  assign cpu_req_s = '{addr: cpu_addr_i, we: cpu_we_i, wdata: cpu_wdata_i};
  assign dma_req_s = '{addr: dma_addr_i, we: dma_we_i, wdata: dma_wdata_i};
  assign gnt_req   = dma_gnt ? dma_req_s : cpu_req_s;

  assign unused_addr_bits = ^{gnt_req.addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], gnt_req.addr[1:0]};

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && (cpu_we_i == '0))      owner_d = OWN_CPU;
    else if (dma_gnt && (dma_we_i == '0)) owner_d = OWN_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  always_comb begin
    cpu_gnt_o    = cpu_gnt;
    dma_gnt_o    = dma_gnt;
    mem_en_o     = cpu_gnt | dma_gnt;
    mem_addr_o   = gnt_req.addr[MEM_ADDR_WIDTH+1:2];
    mem_we_o     = mem_en_o ? gnt_req.we : '0;
    mem_wdata_o  = gnt_req.wdata;
    if (rst) begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
    // rst gating drops a response whose grant happened just before reset.
    cpu_rvalid_o = (owner_q == OWN_CPU) && !rst;
    dma_rvalid_o = (owner_q == OWN_DMA) && !rst;
    cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
    dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: cycle-level model plus directed literal checks.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, dma_req;
  logic [31:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata;
  logic [3:0]  cpu_we, dma_we;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        cpu_lock = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_we_i(cpu_we), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dma_req_i(dma_req), .dma_addr_i(dma_addr), .dma_we_i(dma_we), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .cpu_lock_i(cpu_lock),
`endif
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // RAM environment; returns junk when not read so stale data cannot pass unnoticed.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_en && mem_we == 4'b0) mem_rdata <= ram[mem_addr];
    else                          mem_rdata <= 32'hDEAD_BEEF;
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Model state: DMA wait count, pending response owner/data, who got the last grant.
  int          m_starve = 0;
  bit          m_pend_cpu = 0, m_pend_dma = 0, m_last_cpu = 0;
  logic [31:0] m_pend_data = '0;
  bit          chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit          hold, dwins, cg, dg;
      logic [31:0] a, wd;
      logic [3:0]  we;
      hold = 0;
`ifdef DMEM_ARB_LOCK_EN
      hold = cpu_lock && m_last_cpu;
`endif
      if (rst) begin
        cg = 0; dg = 0;
        a = '0; wd = '0; we = '0;
      end else begin
        dwins = (m_starve == LIM);
        dg = dma_req && !hold && (!cpu_req || dwins);
        cg = cpu_req && !dg;
        a  = dg ? dma_addr : cpu_addr;
        wd = dg ? dma_wdata : cpu_wdata;
        we = cg ? cpu_we : (dg ? dma_we : 4'b0);
      end
      chk("m cpu_gnt", cpu_gnt, cg);
      chk("m dma_gnt", dma_gnt, dg);
      chk("m mem_en", mem_en, cg | dg);
      chk("m mem_addr", mem_addr, a[11:2]);
      chk("m mem_we", mem_we, we);
      chk("m mem_wdata", mem_wdata, wd);
      chk("m cpu_rvalid", cpu_rvalid, m_pend_cpu && !rst);
      chk("m dma_rvalid", dma_rvalid, m_pend_dma && !rst);
      chk("m cpu_rdata", cpu_rdata, (m_pend_cpu && !rst) ? m_pend_data : 32'h0);
      chk("m dma_rdata", dma_rdata, (m_pend_dma && !rst) ? m_pend_data : 32'h0);
      if (rst) begin
        m_starve = 0; m_pend_cpu = 0; m_pend_dma = 0; m_last_cpu = 0;
      end else begin
        m_pend_cpu  = cg && cpu_we == 4'b0;
        m_pend_dma  = dg && dma_we == 4'b0;
        m_pend_data = ram[a[11:2]];
        if (!dma_req || dg)    m_starve = 0;
        else if (m_starve < LIM) m_starve++;
        if (cg)      m_last_cpu = 1;
        else if (dg) m_last_cpu = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit r, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    cpu_req = r; cpu_addr = a; cpu_we = w; cpu_wdata = d;
  endtask

  task automatic set_dma(input bit r, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    dma_req = r; dma_addr = a; dma_we = w; dma_wdata = d;
  endtask

  logic [9:0] v;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | i;
    ram[64] = 32'h5;
    rst = 1'b1;
    set_cpu(0, '0, '0, '0);
    set_dma(0, '0, '0, '0);
    step();
    chk_en = 1;
    step();
    set_cpu(1, 32'h100, 4'h0, 32'h0);
    @(negedge clk);
    chk("reset cpu_gnt", cpu_gnt, 0);
    chk("reset mem_en", mem_en, 0);
    chk("reset mem_addr", mem_addr, 0);
    step();
    rst = 1'b0;

    // 1: lone CPU read of RAM[64]
    @(negedge clk);
    chk("t1 cpu_gnt", cpu_gnt, 1);
    chk("t1 mem_addr", mem_addr, 64);
    step();
    set_cpu(0, 32'h100, 4'h0, 32'h0);
    @(negedge clk);
    chk("t1 cpu_rvalid", cpu_rvalid, 1);
    chk("t1 cpu_rdata", cpu_rdata, 32'h5);
    chk("t1 dma_rvalid", dma_rvalid, 0);
    step();

    // 2: byte-lane write, then read back through a wrapped, misaligned address
    set_cpu(1, 32'h104, 4'b0010, 32'hAABB_CCDD);
    @(negedge clk);
    chk("t2 mem_we", mem_we, 4'b0010);
    chk("t2 mem_addr", mem_addr, 65);
    step();
    set_cpu(1, 32'h0000_1106, 4'h0, 32'h0);
    @(negedge clk);
    chk("t2 no rvalid", {cpu_rvalid, dma_rvalid}, 0);
    chk("t2 wrap addr", mem_addr, 65);
    step();
    set_cpu(0, '0, '0, '0);
    @(negedge clk);
    chk("t2 readback", cpu_rdata, 32'hA500_CC41);
    step();

    // 3: continuous conflict, DMA wins every fifth cycle
    set_cpu(1, 32'h200, 4'h0, 32'h0);
    set_dma(1, 32'h300, 4'h0, 32'h0);
    v = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v[i] = dma_gnt;
      step();
    end
    chk("t3 dma pattern", v, 10'b10_0001_0000);
    set_cpu(0, '0, '0, '0);
    set_dma(0, '0, '0, '0);
    step();

    // 4: interleaved reads C, D, C
    set_cpu(1, 32'h10, 4'h0, 32'h0);
    step();
    set_cpu(0, '0, '0, '0);
    set_dma(1, 32'h14, 4'h0, 32'h0);
    @(negedge clk);
    chk("t4 lone dma gnt", dma_gnt, 1);
    chk("t4 cpu rdata", cpu_rdata, 32'hA500_0004);
    step();
    set_dma(0, '0, '0, '0);
    set_cpu(1, 32'h18, 4'h0, 32'h0);
    @(negedge clk);
    chk("t4 dma rdata", dma_rdata, 32'hA500_0005);
    chk("t4 cpu rvalid low", cpu_rvalid, 0);
    step();
    set_cpu(0, '0, '0, '0);
    @(negedge clk);
    chk("t4 cpu rdata2", cpu_rdata, 32'hA500_0006);
    chk("t4 dma rvalid low", dma_rvalid, 0);
    step();

    // 5a: reset the cycle after a DMA read grant
    set_dma(1, 32'h20, 4'h0, 32'h0);
    step();
    rst = 1'b1;
    set_dma(0, '0, '0, '0);
    set_cpu(1, 32'h40, 4'hF, 32'h1);
    @(negedge clk);
    chk("t5 dma_rvalid", dma_rvalid, 0);
    chk("t5 cpu_gnt", cpu_gnt, 0);
    chk("t5 mem_we", mem_we, 0);
    step();
    rst = 1'b0;
    set_cpu(0, '0, '0, '0);
    @(negedge clk);
    chk("t5 post dma_rvalid", dma_rvalid, 0);
    step();

    // 5b: reset clears a part-filled starvation count
    set_cpu(1, 32'h200, 4'h0, 32'h0);
    set_dma(1, 32'h300, 4'h0, 32'h0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v[i] = dma_gnt;
      step();
    end
    chk("t5 starve restart", v, 10'b00_0001_0000);

`ifdef DMEM_ARB_LOCK_EN
    // 6: lock holds DMA off, DMA wins at once when released
    cpu_lock = 1'b1;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v[i] = dma_gnt;
      step();
    end
    chk("t6 locked dma_gnt", v, 10'b0);
    cpu_lock = 1'b0;
    @(negedge clk);
    chk("t6 release dma_gnt", dma_gnt, 1);
    step();
`endif

    set_cpu(0, '0, '0, '0);
    set_dma(0, '0, '0, '0);
    repeat (2) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
